// File: rtl/ddr_rd_engine_pkg.sv
// Shared definitions for the DDR read engine: command code, state encoding, default widths.
package ddr_rd_engine_pkg;

    localparam logic [2:0] APP_CMD_RD = 3'b001;

    localparam int unsigned DDR_ADDR_W = 28;
    localparam int unsigned DDR_DATA_W = 128;

    // One-hot engine states
    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StRun   = 3'b010,
        StDrain = 3'b100
    } state_e;

endpackage

// File: rtl/ddr_rd_engine_if.sv
// User-side and DDR app-side signals of the read engine.
// The engine uses the slave modport; the surrounding logic uses the master modport.
interface ddr_rd_engine_if
    import ddr_rd_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = DDR_ADDR_W,
    parameter int unsigned DATA_W = DDR_DATA_W,
    parameter int unsigned BL_W   = 8
);
    // user request side
    logic              en;
    logic [BL_W-1:0]   bl;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ring_lo;
    logic [ADDR_W-1:0] ring_hi;
    // user data side
    logic [DATA_W-1:0] dat_o;
    logic              nd;
    logic              dat_rdy;
    logic              done;
    logic              busy;
    // DDR controller app side
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_en;
    logic              app_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_end;
    logic              app_rd_data_valid;

    modport slave (
        input  en, bl, addr, ring_lo, ring_hi, dat_rdy,
        input  app_rdy, app_rd_data, app_rd_data_end, app_rd_data_valid,
        output dat_o, nd, done, busy, app_cmd, app_addr, app_en
    );

    modport master (
        output en, bl, addr, ring_lo, ring_hi, dat_rdy,
        output app_rdy, app_rd_data, app_rd_data_end, app_rd_data_valid,
        input  dat_o, nd, done, busy, app_cmd, app_addr, app_en
    );

endinterface

// File: rtl/ddr_rd_fifo.sv
// Synchronous show-ahead FIFO holding returned read beats until the user drains them.
module ddr_rd_fifo
    import ddr_rd_engine_pkg::*;
#(
    parameter int unsigned DATA_W  = DDR_DATA_W,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [FIFO_AW:0]  count
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal alongside a pop (slot being vacated)
    assign pop  = rd_en && !empty;
    assign push = wr_en && (!full || pop);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The engine's credit scheme must make this unreachable
    overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full && !rd_en))
        else $error("ddr_rd_fifo: write into full FIFO");

endmodule

// File: rtl/ddr_rd_engine.sv
// Issues a run of read commands over a ring address window and buffers the returned
// beats; commands are credit-limited so the return FIFO cannot overflow.
module ddr_rd_engine
    import ddr_rd_engine_pkg::*;
#(
    parameter int unsigned ADDR_W  = DDR_ADDR_W,
    parameter int unsigned DATA_W  = DDR_DATA_W,
    parameter int unsigned BURST_L = 8,
    parameter int unsigned BL_W    = 8,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ddr_rd_engine_if.slave bus
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 2;

    state_e            state_q, state_d;
    logic [BL_W-1:0]   bl_q, bl_d;
    logic [BL_W-1:0]   cmd_cnt_q, cmd_cnt_d;
    logic [BL_W-1:0]   rcv_cnt_q, rcv_cnt_d;
    logic [BL_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] nxt_addr;
    logic [FIFO_AW:0]  fifo_count;
    logic [FIFO_AW:0]  outstanding;
    logic [CW-1:0]     credit_used;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty, fifo_full;
    logic              active, app_en_w, cmd_fire, beat_in, beat_pop;
    logic              unused_sigs;

    assign active      = (state_q != StIdle);
    assign outstanding = (FIFO_AW+1)'(cmd_cnt_q - rcv_cnt_q);
    // Beats already buffered plus beats still owed by the controller
    assign credit_used = CW'(fifo_count) + CW'(outstanding);
    assign app_en_w    = (state_q == StRun) && (cmd_cnt_q < bl_q) && (credit_used < CW'(DEPTH));
    assign cmd_fire    = app_en_w && bus.app_rdy;
    assign beat_in     = active && bus.app_rd_data_valid;
    assign beat_pop    = !fifo_empty && bus.dat_rdy;
    assign nxt_addr    = cur_addr_q + ADDR_W'(BURST_L);

    assign unused_sigs = ^{bus.app_rd_data_end, fifo_full};

    ddr_rd_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (beat_in),
        .din   (bus.app_rd_data),
        .rd_en (beat_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign bus.dat_o    = fifo_dout;
    assign bus.nd       = !fifo_empty;
    assign bus.done     = done_q;
    assign bus.busy     = active;
    assign bus.app_cmd  = APP_CMD_RD;
    assign bus.app_addr = cur_addr_q;
    assign bus.app_en   = app_en_w;

    // Next-state: FSM, counters and ring-wrapped command address
    always_comb begin
        state_d    = state_q;
        bl_d       = bl_q;
        cur_addr_d = cur_addr_q;
        cmd_cnt_d  = cmd_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        done_d     = 1'b0;

        if (cmd_fire) begin
            cmd_cnt_d  = cmd_cnt_q + BL_W'(1);
            cur_addr_d = (nxt_addr >= bus.ring_hi) ? bus.ring_lo : nxt_addr;
        end
        if (beat_in) begin
            rcv_cnt_d = rcv_cnt_q + BL_W'(1);
        end
        if (beat_pop && active) begin
            pop_cnt_d = pop_cnt_q + BL_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.en && (bus.bl != '0)) begin
                    state_d    = StRun;
                    bl_d       = bus.bl;
                    cur_addr_d = bus.addr;
                    cmd_cnt_d  = '0;
                    rcv_cnt_d  = '0;
                    pop_cnt_d  = '0;
                end
            end
            StRun: begin
                if (cmd_fire && (cmd_cnt_d == bl_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (beat_pop && (pop_cnt_d == bl_q)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bl_q       <= '0;
            cur_addr_q <= '0;
            cmd_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bl_q       <= bl_d;
            cur_addr_q <= cur_addr_d;
            cmd_cnt_q  <= cmd_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: doc/ddr_rd_engine.md
Name: ddr_rd_engine

Overview:
- Parametrised read engine between user logic and the DDR controller app interface (native UI).
- Issues a run of `bl` read commands from a start address. Address wraps inside a programmable ring window.
- Returned beats are buffered in an internal FIFO. The user drains them with a valid/ready handshake.
- Commands are credit-limited so the FIFO can never overflow, even when the user stalls.

Parameters:
- ADDR_W, 28, app/user address width
- DATA_W, 128, app data width
- BURST_L, 8, address increment per command
- BL_W, 8, width of burst-count input; full range 1..2^BL_W-1
- FIFO_AW, 4, log2 of return-FIFO depth (DEPTH = 2^FIFO_AW = 16)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; sampled only in IDLE
- bl  in  BL_W  number of read commands/beats; 0 = request ignored
- addr  in  ADDR_W  start address; must lie in [ring_lo, ring_hi)
- ring_lo  in  ADDR_W  ring window base (inclusive)
- ring_hi  in  ADDR_W  ring window limit (exclusive)
- dat_o  out  DATA_W  FIFO head data (show-ahead)
- nd  out  1  dat_o valid (FIFO non-empty)
- dat_rdy  in  1  user accepts dat_o when nd&dat_rdy
- done  out  1  one-cycle pulse after last beat popped
- busy  out  1  high from accepted start to done
- app_cmd  out  3  constant 3'b001 (read)
- app_addr  out  ADDR_W  current command address
- app_en  out  1  command request
- app_rdy  in  1  controller accepts command when app_en&app_rdy
- app_rd_data  in  DATA_W  returned read data
- app_rd_data_end  in  1  unused; kept for interface compatibility
- app_rd_data_valid  in  1  returned beat valid

Behaviour:
- Reset values: busy=0, done=0, nd=0, app_en=0, app_addr=0, dat_o=0, FIFO empty, all counters 0, state=IDLE.
- States: IDLE, RUN, DRAIN.
- IDLE→RUN: en & bl!=0. Latch bl_reg=bl (full BL_W bits) and cur_addr=addr. busy rises next cycle.
- In IDLE, en with bl==0 is ignored: no state change, no done.
- Counters:
  - cmd_cnt: commands accepted (app_en&app_rdy).
  - rcv_cnt: beats received (app_rd_data_valid, RUN/DRAIN only).
  - pop_cnt: beats popped.
  - outstanding = cmd_cnt − rcv_cnt (FIFO_AW+1 bits).
- app_en is combinational: state==RUN & cmd_cnt<bl_reg & (fifo_count+outstanding) < DEPTH.
- app_addr=cur_addr. On app_en&app_rdy: nxt=cur_addr+BURST_L; cur_addr = (nxt>=ring_hi) ? ring_lo : nxt. The ADDR_W-bit compare ignores carry-out.
- app_rdy low holds app_en and app_addr stable. No command is lost.
- RUN→DRAIN on the cycle the bl_reg-th command is accepted.
- DRAIN→IDLE when pop_cnt==bl_reg, i.e. on the cycle the final pop occurs. done=1 for exactly the next cycle, and busy falls in that same cycle.
- app_rd_data_valid is always written to the FIFO in RUN/DRAIN. The credit rule guarantees space.
- app_rd_data_valid in IDLE is discarded.
- FIFO:
  - show-ahead; latency write→nd = 1 cycle.
  - Simultaneous push and pop keeps the count constant.
  - Pop only when nd&dat_rdy.
  - A full FIFO with valid data arriving is impossible by construction. Assertion fires in simulation.
- dat_rdy may be held low indefinitely. The engine then stalls commands after DEPTH credits are consumed.
- en during RUN/DRAIN is ignored; a new job is never queued.
- Reset mid-operation: all state is cleared immediately. Controller data already in flight after reset release is dropped because state is IDLE.

Decomposition:
- Shared package: APP_CMD_RD=3'b001, state encodings (IDLE/RUN/DRAIN one-hot, 3 bits), DDR common widths (ADDR_W, DATA_W defaults).
- One sub-module: ddr_rd_fifo, a synchronous show-ahead FIFO.
  - Parameters: DATA_W, FIFO_AW.
  - Ports: wr_en/din, rd_en/dout, empty/full, count.
  - Same clk/rst_n.

Test Plan:
- Basic run: addr=0x100, bl=4, ring 0..0x10000, app_rdy=1, dat_rdy=1, data returns 3 cycles after each command → app_addr 0x100,0x108,0x110,0x118; 4 nd pulses, in order; done single pulse one cycle after 4th pop; busy low after.
- Backpressure: bl=40, dat_rdy=0, immediate returns → app_en deasserts after exactly 16 commands; nd stays 1. Release dat_rdy → remaining 24 issued, 40 beats delivered, no overflow assertion.
- app_rdy stall: app_rdy toggles 1,0,0,1 → app_addr held across stall cycles, no duplicate or skipped addresses, cmd_cnt=bl at end.
- Ring wrap: ring_lo=0x200, ring_hi=0x220, addr=0x210, bl=4 → app_addr 0x210,0x218,0x200,0x208.
- Boundaries: bl=0 with en → no busy, no app_en. bl=255 → 255 commands (full-width count), done once. en pulsed mid-RUN → ignored.
- Reset mid-op: assert rst_n low after 3 of 8 commands → all outputs 0 next edge. Late app_rd_data_valid after release → nd stays 0. A new job then completes normally.
